// File: rtl/wb_grf.sv
// Write-back stage and 32x32 general register file for the five-stage MIPS pipeline.
// Forms the write-back value, commits it, and serves two bypassed read ports plus a retire trace.
module wb_grf (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_W,
  input  logic [3:0]  MemtoReg_W,
  input  logic [31:0] PC_W,
  input  logic [31:0] PC8_W,
  input  logic [31:0] ALUresult_W,
  input  logic [31:0] MemOutput_W,
  input  logic [4:0]  Dst_W,
  input  logic [31:0] Instruction_W,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] WD_W,
  output logic        Trace_Valid,
  output logic [31:0] Trace_PC,
  output logic [4:0]  Trace_Reg,
  output logic [31:0] Trace_Data,
  output logic [31:0] RetireCount
);

  logic [31:0] rf [32];
  logic [31:0] retire_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        commit;
  logic        unused_instr;

  // The instruction word travels with W only for debug visibility.
  assign unused_instr = ^Instruction_W;

  assign commit = RegWrite_W && (Dst_W != 5'd0);

  always_comb begin
    byte_sel = MemOutput_W[7:0];
    case (ALUresult_W[1:0])
      2'd0: byte_sel = MemOutput_W[7:0];
      2'd1: byte_sel = MemOutput_W[15:8];
      2'd2: byte_sel = MemOutput_W[23:16];
      2'd3: byte_sel = MemOutput_W[31:24];
      default: byte_sel = MemOutput_W[7:0];
    endcase
    half_sel = ALUresult_W[1] ? MemOutput_W[31:16] : MemOutput_W[15:0];
  end

  always_comb begin
    WD_W = ALUresult_W;
    case (MemtoReg_W)
      4'd1: WD_W = MemOutput_W;
      4'd2: WD_W = PC8_W;
      4'd3: WD_W = {{24{byte_sel[7]}}, byte_sel};
      4'd4: WD_W = {24'd0, byte_sel};
      4'd5: WD_W = {{16{half_sel[15]}}, half_sel};
      4'd6: WD_W = {16'd0, half_sel};
      default: WD_W = ALUresult_W;
    endcase
  end

  // Same-cycle bypass gives decode a zero-latency read-after-write.
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (A1 != 5'd0) RD1 = (commit && (A1 == Dst_W)) ? WD_W : rf[A1];
    if (A2 != 5'd0) RD2 = (commit && (A2 == Dst_W)) ? WD_W : rf[A2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf          <= '{default: '0};
      Trace_Valid <= 1'b0;
      Trace_PC    <= '0;
      Trace_Reg   <= '0;
      Trace_Data  <= '0;
      retire_q    <= '0;
    end else begin
      Trace_Valid <= commit;
      if (commit) begin
        rf[Dst_W]  <= WD_W;
        Trace_PC   <= PC_W;
        Trace_Reg  <= Dst_W;
        Trace_Data <= WD_W;
      end
      if (PC_W != 32'd0) retire_q <= retire_q + 32'd1;
    end
  end

  assign RetireCount = retire_q;

endmodule

// File: doc/wb_grf.md
# wb_grf

Write-back stage and general register file for the five-stage MIPS pipeline. Consumes the MEM/WB pipeline register outputs, forms the write-back value (ALU result, extended load data or link address) and commits it into a 32×32 register file. Provides two combinational read ports with internal write-through bypass to the decode stage, plus a registered retire trace and retire counter for the bench.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high; one clock; clears all state
- RegWrite_W  in  1  register write enable from MEM/WB
- MemtoReg_W  in  4  write-back source select (encoding under Operation)
- PC_W  in  32  PC of instruction in W; 0 marks a bubble
- PC8_W  in  32  link address (PC+8)
- ALUresult_W  in  32  ALU/HI/LO result; also the load byte address
- MemOutput_W  in  32  raw aligned word read from data memory
- Dst_W  in  5  destination register number
- Instruction_W  in  32  instruction word in W
- A1, A2  in  5  decode-stage read addresses
- RD1, RD2  out  32  read data (combinational, bypassed)
- WD_W  out  32  write-back value (combinational; used by forwarding)
- Trace_Valid  out  1  registered: a register write committed last cycle
- Trace_PC  out  32  registered PC of committed write
- Trace_Reg  out  5  registered destination of committed write
- Trace_Data  out  32  registered data of committed write
- RetireCount  out  32  registered count of retired instructions

## Operation
- MemtoReg_W encoding: 0 ALUresult_W; 1 MemOutput_W (lw); 2 PC8_W; 3 lb (sign-ext byte); 4 lbu (zero-ext byte); 5 lh (sign-ext half); 6 lhu (zero-ext half); 7–15 ALUresult_W.
- Byte select: ALUresult_W[1:0]=0→bits[7:0], 1→[15:8], 2→[23:16], 3→[31:24] of MemOutput_W.
- Half select: ALUresult_W[1]=0→bits[15:0], 1→[31:16]; ALUresult_W[0] ignored (misalignment trapped upstream).
- Commit condition: RegWrite_W=1 and Dst_W≠0. Register 0 never written; reads of 0 return 0 always.
- Read port: if commit condition holds and Ax==Dst_W, RDx=WD_W; else RDx=stored value. Bypass on A1 and A2 independently.
- Trace: on each posedge, Trace_Valid<=commit condition; Trace_PC/Reg/Data <= PC_W/Dst_W/WD_W when committing, else hold previous values.
- Retire: RetireCount increments by 1 on each posedge with PC_W≠0, independent of RegWrite_W; wraps 0xFFFFFFFF→0.

## Timing
- Register write: value visible in storage after the posedge where commit condition held; visible to RDx in the same cycle via bypass (zero-latency read-after-write).
- WD_W, RD1, RD2: purely combinational from current inputs and storage.
- Trace and RetireCount: latency 1 cycle after the instruction occupies W.
- Reset (synchronous): all 32 registers, Trace_Valid, Trace_PC, Trace_Reg, Trace_Data and RetireCount <= 0. Reset dominates a simultaneous commit: that write is dropped and not counted.
- Reset asserted mid-stream: next cycle all outputs except combinational ones are 0; RD1/RD2 return 0 for non-bypassed addresses.
- Bubble (all inputs 0): no write, no count, Trace_Valid<=0.
- Simultaneous read and write of same register: bypass value returned; write of Dst_W=0 with A1=0 returns 0.

## Test plan
- Reset then RegWrite_W=1, Dst_W=5, MemtoReg_W=0, ALUresult_W=0x1234, PC_W=0x3000, A1=5 -> RD1=0x1234 same cycle; next cycle Trace_Valid=1, Trace_Reg=5, Trace_PC=0x3000, RetireCount=1.
- MemOutput_W=0x80FF7F01, MemtoReg_W=3/4 with ALUresult_W[1:0]=3 -> WD_W=0xFFFFFF80 / 0x00000080; MemtoReg_W=5/6 with ALUresult_W[1]=1 -> 0xFFFF80FF / 0x000080FF.
- MemtoReg_W=2, PC8_W=0x3008, Dst_W=31 -> $31=0x3008; MemtoReg_W=9 -> WD_W=ALUresult_W.
- RegWrite_W=1, Dst_W=0, WD_W=0xDEAD, A2=0 -> RD2=0 now and later; Trace_Valid=0; RetireCount still increments if PC_W≠0.
- Write $7=0xAAAA, next cycle reset with commit to $7=0xBBBB -> $7 reads 0, RetireCount=0, Trace_Valid=0.
- Preload RetireCount to 0xFFFFFFFF via 2^32-1 retires (or force), one more retire -> 0.
